exibe_sequencia: RTL and testbench

Sequence presenter for the memory game: on a start pulse it reads the 16x4 sequence ROM from address 0 up to a sampled limit and drives each stored value onto the LEDs for a fixed on-time, followed by a blank off-time. It is the "show" side of the round, feeding the player the sequence that the play-checking datapath later compares against button presses. It sits between the game control unit (start/done handshake) and a synchronous ROM read port.

---
 rtl/exibe_sequencia.sv | 103 ++++++++++
 tb/tb_exibe_sequencia.sv | 137 +++++++++++++
 2 files changed

// File: rtl/exibe_sequencia.sv
// Sequence presenter: reads the sequence ROM from address 0 up to a latched limit,
// showing each value on the LEDs for T_ACESO cycles followed by T_APAGADO blank cycles.
module exibe_sequencia #(
  parameter int unsigned T_ACESO   = 1000,
  parameter int unsigned T_APAGADO = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  output logic [3:0] mem_endereco,
  input  logic [3:0] mem_dado,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [15:0] ACESO_ULT   = 16'(T_ACESO - 1);
  localparam logic [15:0] APAGADO_ULT = 16'(T_APAGADO - 1);

  estado_t     estado;
  estado_t     estado_prox;
  logic [15:0] timer;
  logic [3:0]  limite_reg;
  logic        fim_aceso;
  logic        fim_apagado;
  logic        ultimo;

  assign fim_aceso   = (timer == ACESO_ULT);
  assign fim_apagado = (timer == APAGADO_ULT);
  assign ultimo      = (mem_endereco == limite_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (iniciar) estado_prox = CARREGA;
      CARREGA: estado_prox = ACESO;
      ACESO:   if (fim_aceso) estado_prox = APAGADO;
      APAGADO: if (fim_apagado) estado_prox = ultimo ? FIM : CARREGA;
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // Timer only runs while ACESO/APAGADO persist; any state change clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      mem_endereco <= '0;
      limite_reg   <= '0;
    end else begin
      if ((estado_prox != estado) || !((estado == ACESO) || (estado == APAGADO))) begin
        timer <= '0;
      end else begin
        timer <= timer + 16'd1;
      end
      case (estado)
        OCIOSO: begin
          mem_endereco <= '0;
          if (iniciar) limite_reg <= limite;
        end
        APAGADO: if (fim_apagado && !ultimo) mem_endereco <= mem_endereco + 4'd1;
        FIM:     mem_endereco <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    leds      = '0;
    exibindo  = 1'b0;
    pronto    = 1'b0;
    db_estado = estado;
    case (estado)
      CARREGA: exibindo = 1'b1;
      ACESO: begin
        exibindo = 1'b1;
        leds     = mem_dado;
      end
      APAGADO: exibindo = 1'b1;
      FIM:     pronto   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ACESO=3, T_APAGADO=2 and a synchronous ROM
// holding data[i] = 1 << (i mod 4).
module tb_exibe_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] mem_endereco;
  logic [3:0] mem_dado = '0;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [2:0] db_estado;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exibe_sequencia #(.T_ACESO(3), .T_APAGADO(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .limite      (limite),
    .mem_endereco(mem_endereco),
    .mem_dado    (mem_dado),
    .leds        (leds),
    .exibindo    (exibindo),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_dado <= 4'b0001 << mem_endereco[1:0];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_leds, input logic [3:0] e_addr,
                            input logic e_exib, input logic e_pronto, input logic [2:0] e_db);
    check({tag, ".leds"},     16'(leds),         16'(e_leds));
    check({tag, ".addr"},     16'(mem_endereco), 16'(e_addr));
    check({tag, ".exibindo"}, 16'(exibindo),     16'(e_exib));
    check({tag, ".pronto"},   16'(pronto),       16'(e_pronto));
    check({tag, ".estado"},   16'(db_estado),    16'(e_db));
  endtask

  // Start a run with limit lim; optionally disturb iniciar/limite at cycle 'disturb'.
  // Cycle c counts edges after the sampling edge E: each item is 6 cycles
  // (CARREGA, 3x ACESO, 2x APAGADO), then FIM at c = (lim+1)*6.
  task automatic run(input string tag, input int lim, input int disturb);
    int fim_c;
    int k;
    int p;
    logic [3:0] e_leds;
    fim_c = (lim + 1) * 6;
    limite  = 4'(lim);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 0; c <= fim_c; c++) begin
      k = c / 6;
      p = c % 6;
      if (c == fim_c) begin
        check_outs({tag, ".fim"}, 4'd0, 4'(lim), 1'b0, 1'b1, 3'd4);
      end else if (p == 0) begin
        check_outs({tag, ".carrega"}, 4'd0, 4'(k), 1'b1, 1'b0, 3'd1);
      end else if (p <= 3) begin
        e_leds = 4'b0001 << (k % 4);
        check_outs({tag, ".aceso"}, e_leds, 4'(k), 1'b1, 1'b0, 3'd2);
      end else begin
        check_outs({tag, ".apagado"}, 4'd0, 4'(k), 1'b1, 1'b0, 3'd3);
      end
      if (c == disturb) begin
        iniciar = 1'b1;
        limite  = 4'd0;
      end
      if (c == disturb + 1) iniciar = 1'b0;
      tick();
    end
    check_outs({tag, ".ocioso"}, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    // Reset idle
    tick();
    tick();
    check_outs("rst_held", 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("idle", 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
    end

    run("single", 0, -1);
    tick();
    run("three", 2, -1);
    tick();
    run("full", 15, -1);
    tick();
    run("ignored", 2, 8);
    tick();

    // Reset mid-run: ACESO of item 1 is cycle 8 after the sampling edge
    limite  = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_outs("pre_abort", 4'b0010, 4'd1, 1'b1, 1'b0, 3'd2);
    reset = 1'b1;
    #1;
    check_outs("abort_now", 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("abort.no_pronto", 16'(pronto), 16'd0);
    end
    check_outs("abort_idle", 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
    run("restart", 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
